// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receiver with a runtime frame format (5-8 data bits,
//            none/even/odd parity, 1 or 2 stop bits). Each bit is sampled
//            three times around mid-bit and resolved by majority vote.
//            Finished frames and their error flags go into a small FIFO
//            with a valid/ready read port.
// Ports    : clk, resetn (synchronous, active low)
//            divider        - bit period minus 1 (>=3)
//            cfg_*          - frame format, sampled live
//            uart_rxd       - asynchronous serial input
//            uart_rx_en     - receiver enable
//            rx_valid/rx_ready, rx_data, rx_perr, rx_ferr, rx_break - head entry
//            rx_level       - FIFO occupancy
//            rx_overrun     - sticky drop flag; clr_overrun clears it
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] divider,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             uart_rxd,
  input  logic             uart_rx_en,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_break,
  output logic [LVL_W-1:0] rx_level,
  output logic             rx_overrun,
  input  logic             clr_overrun
);

  localparam int c_AW = LVL_W - 1;
  localparam logic [LVL_W-1:0] c_DEPTH = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP1  = 3'd4;
  localparam logic [2:0] c_ST_STOP2  = 3'd5;

  logic [2:0]       r_state, w_state_next;
  logic             r_sync1, r_sync2;
  logic [DIV_W-1:0] r_cyc;
  logic             r_s0, r_s1;
  logic [7:0]       r_data;
  logic [2:0]       r_bitcnt;
  logic             r_pbit, r_stop1, r_brk_wait;

  logic             w_rxd, w_maj, w_resolve, w_bit_end, w_last_bit, w_par_en;
  logic [DIV_W-1:0] w_half;
  logic             w_done, w_stop1_val, w_ferr, w_perr, w_break;
  logic [10:0]      w_entry;

  // ---------------- input synchroniser ----------------
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd      = r_sync2;
  assign w_half     = divider >> 1;
  assign w_bit_end  = (r_cyc == divider);
  assign w_resolve  = (r_state != c_ST_IDLE) && (r_cyc == w_half + DIV_W'(1));
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
  assign w_last_bit = (r_bitcnt == (3'd4 + {1'b0, cfg_data_bits}));
  assign w_par_en   = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= c_ST_IDLE;
    else         r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (!uart_rx_en) begin
      w_state_next = c_ST_IDLE;
    end else begin
      case (r_state)
        // After a break the line is still low; wait for it to go high
        // before treating a low level as a new start bit.
        c_ST_IDLE:   if (!w_rxd && !r_brk_wait) w_state_next = c_ST_START;
        c_ST_START: begin
          if (w_resolve && w_maj) w_state_next = c_ST_IDLE;
          else if (w_bit_end)     w_state_next = c_ST_DATA;
        end
        c_ST_DATA:   if (w_bit_end && w_last_bit)
                       w_state_next = w_par_en ? c_ST_PARITY : c_ST_STOP1;
        c_ST_PARITY: if (w_bit_end) w_state_next = c_ST_STOP1;
        c_ST_STOP1: begin
          // Single stop bit: finish at mid-bit so a following start edge
          // arriving early is still caught.
          if (w_resolve && !cfg_stop2)     w_state_next = c_ST_IDLE;
          else if (w_bit_end && cfg_stop2) w_state_next = c_ST_STOP2;
        end
        c_ST_STOP2:  if (w_resolve) w_state_next = c_ST_IDLE;
        default:     w_state_next = c_ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs (frame completion) ----------------
  always_comb begin
    w_done      = 1'b0;
    w_stop1_val = r_stop1;
    if (uart_rx_en && w_resolve &&
        ((r_state == c_ST_STOP1 && !cfg_stop2) || r_state == c_ST_STOP2))
      w_done = 1'b1;
    if (r_state == c_ST_STOP1) w_stop1_val = w_maj;
    w_ferr  = !w_stop1_val || ((r_state == c_ST_STOP2) && !w_maj);
    w_break = (r_data == 8'h00) && !(w_par_en && r_pbit) && !w_stop1_val;
    w_perr  = w_par_en && (((^r_data) ^ r_pbit) != (cfg_parity == 2'd2));
    w_entry = {w_break, w_ferr, w_perr, r_data};
  end

  // ---------------- bit timing and data path ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cyc      <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_data     <= 8'h00;
      r_bitcnt   <= 3'd0;
      r_pbit     <= 1'b0;
      r_stop1    <= 1'b0;
      r_brk_wait <= 1'b0;
    end else begin
      if (r_state == c_ST_IDLE || w_state_next == c_ST_IDLE || w_bit_end)
        r_cyc <= '0;
      else
        r_cyc <= r_cyc + DIV_W'(1);

      if (r_cyc == w_half - DIV_W'(1)) r_s0 <= w_rxd;
      if (r_cyc == w_half)             r_s1 <= w_rxd;

      if (r_state == c_ST_IDLE) begin
        r_data   <= 8'h00;
        r_bitcnt <= 3'd0;
      end
      if (r_state == c_ST_DATA) begin
        if (w_resolve) r_data[r_bitcnt] <= w_maj;
        if (w_bit_end) r_bitcnt <= w_last_bit ? 3'd0 : r_bitcnt + 3'd1;
      end
      if (r_state == c_ST_PARITY && w_resolve) r_pbit  <= w_maj;
      if (r_state == c_ST_STOP1 && w_resolve)  r_stop1 <= w_maj;

      if (!uart_rx_en)            r_brk_wait <= 1'b0;
      else if (w_done && w_break) r_brk_wait <= 1'b1;
      else if (w_rxd)             r_brk_wait <= 1'b0;
    end
  end

  // ---------------- receive FIFO ----------------
  logic [10:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]  r_wptr, r_rptr, w_rptr_next;
  logic [LVL_W-1:0] r_count, w_count_next, w_cnt_after_pop;
  logic [10:0]      r_head;
  logic             r_ovr;
  logic             w_do_pop, w_do_push;

  assign w_do_pop        = (r_count != '0) && rx_ready;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign w_do_push       = w_done && ((r_count != c_DEPTH) || w_do_pop);
  assign w_rptr_next     = r_rptr + c_AW'(w_do_pop);
  assign w_cnt_after_pop = r_count - LVL_W'(w_do_pop);
  assign w_count_next    = w_cnt_after_pop + LVL_W'(w_do_push);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_AW'(1);
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
      // Head register: bypass the new entry when it lands in an empty FIFO,
      // otherwise show the stored head; hold when the FIFO drains.
      if (w_do_push && w_cnt_after_pop == '0) r_head <= w_entry;
      else if (w_cnt_after_pop != '0)         r_head <= r_mem[w_rptr_next];
      if (w_done && !w_do_push) r_ovr <= 1'b1;
      else if (clr_overrun)     r_ovr <= 1'b0;
    end
  end

  assign rx_valid   = (r_count != '0);
  assign rx_level   = r_count;
  assign rx_data    = r_head[7:0];
  assign rx_perr    = r_head[8];
  assign rx_ferr    = r_head[9];
  assign rx_break   = r_head[10];
  assign rx_overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo at divider=15
//            (16 clocks per bit). Frames are driven bit by bit and the FIFO
//            head is compared with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] divider;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        uart_rxd;
  logic        uart_rx_en;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_ferr;
  logic        rx_break;
  logic [2:0]  rx_level;
  logic        rx_overrun;
  logic        clr_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_rx_fifo #(.DIV_W(16), .FIFO_DEPTH(4), .LVL_W(3)) dut (
    .clk(clk), .resetn(resetn), .divider(divider),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_break(rx_break),
    .rx_level(rx_level), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    clocks(1);
    rx_ready = 1'b0;
  endtask

  // Drives one frame; bit gbit is inverted for one clock at offset goff.
  task automatic send(input logic [7:0] d, input int nbits, input bit use_par,
                      input bit pbit, input bit st1, input bit two, input bit st2,
                      input int gbit, input int goff);
    logic [12:0] bits;
    int nb;
    bits = '0;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < nbits; i++) begin bits[nb] = d[i]; nb++; end
    if (use_par) begin bits[nb] = pbit; nb++; end
    bits[nb] = st1; nb++;
    if (two) begin bits[nb] = st2; nb++; end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 16; c++) begin
        uart_rxd = (b == gbit && c == goff) ? ~bits[b] : bits[b];
        clocks(1);
      end
    end
    uart_rxd = 1'b1;
    clocks(48);
  endtask

  task automatic check_head(input string tag, input logic [2:0] lvl, input logic [7:0] d,
                            input bit pe, input bit fe, input bit br);
    check({tag, "_level"}, 16'(rx_level), 16'(lvl));
    check({tag, "_valid"}, 16'(rx_valid), 16'(lvl != 3'd0));
    check({tag, "_data"},  16'(rx_data),  16'(d));
    check({tag, "_perr"},  16'(rx_perr),  16'(pe));
    check({tag, "_ferr"},  16'(rx_ferr),  16'(fe));
    check({tag, "_break"}, 16'(rx_break), 16'(br));
  endtask

  initial begin
    resetn = 1'b0; divider = 16'd15; cfg_data_bits = 2'd3; cfg_parity = 2'd0;
    cfg_stop2 = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1; rx_ready = 1'b0;
    clr_overrun = 1'b0;
    clocks(3);
    check_head("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_ovr", 16'(rx_overrun), 16'd0);
    resetn = 1'b1;
    clocks(4);

    // 8N1 0xA5
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
    check_head("8n1_a5", 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0);
    pop();
    check("8n1_pop_level", 16'(rx_level), 16'd0);
    check("8n1_pop_valid", 16'(rx_valid), 16'd0);
    check("8n1_hold_data", 16'(rx_data), 16'hA5);

    // 5N1: only the low 5 bits of 0xF5 are sent -> 0x15
    cfg_data_bits = 2'd0;
    send(8'hF5, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
    check_head("5n1", 3'd1, 8'h15, 1'b0, 1'b0, 1'b0);
    pop();

    // 7E2, 0x35 has four ones: even parity bit should be 0
    cfg_data_bits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    send(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
    check_head("7e2_bad_par", 3'd1, 8'h35, 1'b1, 1'b0, 1'b0);
    pop();
    send(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
    check_head("7e2_good_par", 3'd1, 8'h35, 1'b0, 1'b0, 1'b0);
    pop();
    send(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
    check_head("7e2_stop2_low", 3'd1, 8'h35, 1'b0, 1'b1, 1'b0);
    pop();

    // 7O1: parity bit 1 makes five ones -> correct odd parity
    cfg_parity = 2'd2; cfg_stop2 = 1'b0;
    send(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    check_head("7o1", 3'd1, 8'h35, 1'b0, 1'b0, 1'b0);
    pop();

    // 8N1 break: line low for 20 bit times
    cfg_data_bits = 2'd3; cfg_parity = 2'd0;
    uart_rxd = 1'b0;
    clocks(320);
    uart_rxd = 1'b1;
    clocks(64);
    check_head("break", 3'd1, 8'h00, 1'b0, 1'b1, 1'b1);
    pop();
    check("break_drained", 16'(rx_level), 16'd0);

    // false start: 3 clocks low
    uart_rxd = 1'b0;
    clocks(3);
    uart_rxd = 1'b1;
    clocks(48);
    check("false_start_level", 16'(rx_level), 16'd0);
    check("false_start_valid", 16'(rx_valid), 16'd0);
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
    check_head("after_false", 3'd1, 8'h5A, 1'b0, 1'b0, 1'b0);
    pop();

    // glitch on data bit 3 (frame bit 4) at its centre sample
    send(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 8);
    check_head("glitch", 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    pop();

    // overrun: five frames with no reads into a 4-deep FIFO
    for (int i = 1; i <= 5; i++)
      send(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
    check("ovr_level", 16'(rx_level), 16'd4);
    check("ovr_flag", 16'(rx_overrun), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_read_data", 16'(rx_data), 16'(i));
      pop();
    end
    check("ovr_empty", 16'(rx_level), 16'd0);
    check("ovr_sticky", 16'(rx_overrun), 16'd1);
    clr_overrun = 1'b1;
    clocks(1);
    clr_overrun = 1'b0;
    check("ovr_cleared", 16'(rx_overrun), 16'd0);

    // reset in the middle of data bit 4, then a clean 0x3C
    uart_rxd = 1'b0;
    clocks(16);
    clocks(64);
    clocks(8);
    resetn = 1'b0;
    clocks(2);
    uart_rxd = 1'b1;
    resetn = 1'b1;
    clocks(200);
    check("midreset_level", 16'(rx_level), 16'd0);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
    check_head("after_reset", 3'd1, 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
